// File: rtl/vend_pkg.sv
// Shared types and helpers for the multi-item vending controller.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CREDIT = 2'd1,
        VEND   = 2'd2,
        REFUND = 2'd3
    } vend_state_e;

    localparam int STOCK_W   = 8;
    localparam int MAX_ITEMS = 16;

    function automatic logic onehot_valid(input logic [MAX_ITEMS-1:0] v);
        return (v != 16'd0) && ((v & (v - 16'd1)) == 16'd0);
    endfunction

    function automatic logic [3:0] onehot_to_idx(input logic [MAX_ITEMS-1:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < MAX_ITEMS; i++) begin
            if (v[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/vend_timeout_ctr.sv
// Inactivity counter: expire pulses once run has been held for TIMEOUT_CYC-1 cycles
// without a clear.
module vend_timeout_ctr #(
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_r;

    // Count idle cycles, saturating at LAST.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (clear) begin
            cnt_r <= '0;
        end else if (run && (cnt_r != LAST)) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expire = run && !clear && (cnt_r == LAST);

endmodule

// File: rtl/vend_ctrl_multi.sv
// Multi-item vending controller: coin credit, edge-qualified selection, cancel and timeout refund.
// Optional per-item stock tracking is compiled in with `define VEND_STOCK_TRACK_EN.
import vend_pkg::*;

module vend_ctrl_multi #(
    parameter int N_ITEMS = 4,
    parameter int MONEY_W = 16,
    parameter logic [N_ITEMS*MONEY_W-1:0] PRICES = {16'd125, 16'd150, 16'd75, 16'd100},
    parameter int TIMEOUT_CYC = 1000,
    parameter int STOCK_INIT = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               coin_valid,
    input  logic [MONEY_W-1:0] coin_value,
    input  logic [N_ITEMS-1:0] sel,
    input  logic               cancel,
    output logic [MONEY_W-1:0] credit,
    output logic [MONEY_W-1:0] price,
    output logic [N_ITEMS-1:0] selection,
    output logic               vend,
    output logic [MONEY_W-1:0] change,
    output logic               change_valid,
    output logic               coin_reject,
    output logic               err_invalid,
    output logic               err_funds
`ifdef VEND_STOCK_TRACK_EN
    ,
    input  logic               restock,
    input  logic [N_ITEMS-1:0] restock_item,
    output logic [N_ITEMS-1:0] sold_out
`endif
);

    if (N_ITEMS < 2 || N_ITEMS > MAX_ITEMS || TIMEOUT_CYC < 2 ||
        STOCK_INIT < 0 || STOCK_INIT > 255) begin : g_bad_params
        $error("vend_ctrl_multi: parameter out of range");
    end

    vend_state_e        state_r, state_s;
    logic [MONEY_W-1:0] credit_r, credit_s, price_r, price_s, change_r, change_s;
    logic [N_ITEMS-1:0] selection_r, selection_s;
    logic               vend_r, vend_s, change_valid_r, change_valid_s;
    logic               coin_reject_r, coin_reject_s, err_invalid_r, err_invalid_s;
    logic               err_funds_r, err_funds_s, sel_seen_r;
    logic [MAX_ITEMS-1:0] sel_ext_s;
    logic [3:0]         sel_idx_s;
    logic [MONEY_W-1:0] item_price_s;
    logic [MONEY_W:0]   coin_sum_s;
    logic               coin_s, coin_ok_s, sel_evt_s, in_stock_s;
    logic               tmo_clear_s, tmo_run_s, tmo_expire_s;

`ifdef VEND_STOCK_TRACK_EN
    logic [STOCK_W-1:0]   stock_r [N_ITEMS];
    logic [N_ITEMS-1:0]   sold_out_r, sold_out_s;
    logic [MAX_ITEMS-1:0] restock_ext_s;
    logic                 restock_ok_s;
`endif

    vend_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (tmo_clear_s),
        .run    (tmo_run_s),
        .expire (tmo_expire_s)
    );

    // Next-state, credit and pulse decode; priority is cancel > sel > coin > timeout.
    always_comb begin
        sel_ext_s              = '0;
        sel_ext_s[N_ITEMS-1:0] = sel;
        sel_idx_s    = onehot_to_idx(sel_ext_s);
        item_price_s = PRICES[int'(sel_idx_s)*MONEY_W +: MONEY_W];
        coin_sum_s   = {1'b0, credit_r} + {1'b0, coin_value};
        coin_s       = coin_valid && (coin_value != '0);
        sel_evt_s    = (sel != '0) && !sel_seen_r;
        coin_ok_s    = coin_s && !cancel && (sel == '0) && !coin_sum_s[MONEY_W] &&
                       ((state_r == IDLE) || (state_r == CREDIT));
        tmo_run_s    = (state_r == CREDIT);
        tmo_clear_s  = (state_r != CREDIT) || coin_s || sel_evt_s;

`ifdef VEND_STOCK_TRACK_EN
        in_stock_s = 1'b0;
        for (int i = 0; i < N_ITEMS; i++) begin
            in_stock_s = in_stock_s | (sel[i] && (stock_r[i] != '0));
        end
        restock_ext_s              = '0;
        restock_ext_s[N_ITEMS-1:0] = restock_item;
        restock_ok_s = restock && (state_r == IDLE) && onehot_valid(restock_ext_s);
        sold_out_s   = '0;
`else
        in_stock_s = 1'b1;
`endif

        state_s        = state_r;
        credit_s       = credit_r;
        price_s        = price_r;
        selection_s    = '0;
        vend_s         = 1'b0;
        change_s       = '0;
        change_valid_s = 1'b0;
        coin_reject_s  = coin_s && !coin_ok_s;
        err_invalid_s  = 1'b0;
        err_funds_s    = 1'b0;

        case (state_r)
            IDLE: begin
                if (coin_ok_s) begin
                    credit_s = coin_sum_s[MONEY_W-1:0];
                    state_s  = CREDIT;
                end else begin
                    state_s = IDLE;
                end
            end
            CREDIT: begin
                if (cancel) begin
                    change_s       = credit_r;
                    change_valid_s = 1'b1;
                    state_s        = REFUND;
                end else if (sel_evt_s) begin
                    if (!onehot_valid(sel_ext_s)) begin
                        err_invalid_s = 1'b1;
                    end else begin
                        price_s = item_price_s;
                        if (!in_stock_s) begin
`ifdef VEND_STOCK_TRACK_EN
                            sold_out_s = sel;
`endif
                        end else if (credit_r >= item_price_s) begin
                            vend_s         = 1'b1;
                            selection_s    = sel;
                            change_s       = credit_r - item_price_s;
                            change_valid_s = 1'b1;
                            state_s        = VEND;
                        end else begin
                            err_funds_s = 1'b1;
                        end
                    end
                end else if (coin_ok_s) begin
                    credit_s = coin_sum_s[MONEY_W-1:0];
                end else if (tmo_expire_s) begin
                    change_s       = credit_r;
                    change_valid_s = 1'b1;
                    state_s        = REFUND;
                end else begin
                    state_s = CREDIT;
                end
            end
            VEND, REFUND: begin
                credit_s = '0;
                state_s  = IDLE;
            end
            default: begin
                credit_s = '0;
                state_s  = IDLE;
            end
        endcase
    end

    // State, credit and registered output pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= IDLE;
            credit_r       <= '0;
            price_r        <= '0;
            selection_r    <= '0;
            vend_r         <= 1'b0;
            change_r       <= '0;
            change_valid_r <= 1'b0;
            coin_reject_r  <= 1'b0;
            err_invalid_r  <= 1'b0;
            err_funds_r    <= 1'b0;
            sel_seen_r     <= 1'b0;
        end else begin
            state_r        <= state_s;
            credit_r       <= credit_s;
            price_r        <= price_s;
            selection_r    <= selection_s;
            vend_r         <= vend_s;
            change_r       <= change_s;
            change_valid_r <= change_valid_s;
            coin_reject_r  <= coin_reject_s;
            err_invalid_r  <= err_invalid_s;
            err_funds_r    <= err_funds_s;
            sel_seen_r     <= (sel != '0);
        end
    end

`ifdef VEND_STOCK_TRACK_EN
    // Per-item stock: decrement on dispense (never below zero), reload on restock in IDLE.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_ITEMS; i++) begin
            if (reset) begin
                stock_r[i] <= STOCK_W'(STOCK_INIT);
            end else if (vend_s && sel[i] && (stock_r[i] != '0)) begin
                stock_r[i] <= stock_r[i] - STOCK_W'(1);
            end else if (restock_ok_s && restock_item[i]) begin
                stock_r[i] <= STOCK_W'(STOCK_INIT);
            end else begin
                stock_r[i] <= stock_r[i];
            end
        end
        if (reset) begin
            sold_out_r <= '0;
        end else begin
            sold_out_r <= sold_out_s;
        end
    end

    assign sold_out = sold_out_r;
`endif

    assign credit       = credit_r;
    assign price        = price_r;
    assign selection    = selection_r;
    assign vend         = vend_r;
    assign change       = change_r;
    assign change_valid = change_valid_r;
    assign coin_reject  = coin_reject_r;
    assign err_invalid  = err_invalid_r;
    assign err_funds    = err_funds_r;

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Self-checking bench for vend_ctrl_multi: directed scenarios followed by random traffic,
// all compared cycle by cycle against a transaction-level model of the vending rules.
module tb_vend_ctrl_multi;

    localparam int TMO  = 20;
    localparam int SINIT = 1;

    logic        clk = 1'b0;
    logic        reset, coin_valid, cancel;
    logic [15:0] coin_value;
    logic [3:0]  sel;
    logic [15:0] credit, price, change;
    logic [3:0]  selection;
    logic        vend, change_valid, coin_reject, err_invalid, err_funds;
`ifdef VEND_STOCK_TRACK_EN
    logic        restock;
    logic [3:0]  restock_item, sold_out;
    bit          rs_g;
    logic [3:0]  ri_g;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Model of the machine as seen from outside.
    int  prices [4] = '{100, 75, 150, 125};
    int  m_credit, m_price, m_idle, m_stock [4];
    bit  m_active, m_closing, m_sel_prev;
    int  e_change;
    bit  e_vend, e_cv, e_rej, e_inv, e_funds;
    logic [3:0] e_sel, e_so;

    vend_ctrl_multi #(.N_ITEMS(4), .MONEY_W(16), .TIMEOUT_CYC(TMO), .STOCK_INIT(SINIT)) dut (
        .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_value(coin_value),
        .sel(sel), .cancel(cancel), .credit(credit), .price(price), .selection(selection),
        .vend(vend), .change(change), .change_valid(change_valid), .coin_reject(coin_reject),
        .err_invalid(err_invalid), .err_funds(err_funds)
`ifdef VEND_STOCK_TRACK_EN
        , .restock(restock), .restock_item(restock_item), .sold_out(sold_out)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int idx_of(input logic [3:0] v);
        int r = 0;
        for (int i = 0; i < 4; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic check_all();
        check("credit", 32'(credit), 32'(m_credit));
        check("price", 32'(price), 32'(m_price));
        check("selection", 32'(selection), 32'(e_sel));
        check("vend", 32'(vend), 32'(e_vend));
        check("change", 32'(change), 32'(e_change));
        check("change_valid", 32'(change_valid), 32'(e_cv));
        check("coin_reject", 32'(coin_reject), 32'(e_rej));
        check("err_invalid", 32'(err_invalid), 32'(e_inv));
        check("err_funds", 32'(err_funds), 32'(e_funds));
`ifdef VEND_STOCK_TRACK_EN
        check("sold_out", 32'(sold_out), 32'(e_so));
`endif
    endtask

    task automatic do_reset();
        reset = 1'b1; coin_valid = 1'b0; coin_value = '0; sel = '0; cancel = 1'b0;
`ifdef VEND_STOCK_TRACK_EN
        restock = 1'b0; restock_item = '0;
`endif
        m_credit = 0; m_price = 0; m_idle = 0; m_active = 0; m_closing = 0; m_sel_prev = 0;
        for (int i = 0; i < 4; i++) m_stock[i] = SINIT;
        e_sel = '0; e_vend = 0; e_change = 0; e_cv = 0; e_rej = 0; e_inv = 0; e_funds = 0;
        e_so = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        check_all();
    endtask

    task automatic refund_now();
        e_cv = 1; e_change = m_credit; m_closing = 1;
    endtask

    // One clock of stimulus; the model predicts what the outputs show after the edge.
    task automatic step(input bit cv, input int cval, input logic [3:0] s, input bit c);
        bit coin, sel_new;
        int i;
        coin_valid = cv; coin_value = cval[15:0]; sel = s; cancel = c;
        e_sel = '0; e_vend = 0; e_change = 0; e_cv = 0; e_rej = 0; e_inv = 0; e_funds = 0;
        e_so = '0;
        coin    = cv && (cval != 0);
        sel_new = (s != 4'd0) && !m_sel_prev;
`ifdef VEND_STOCK_TRACK_EN
        restock = rs_g; restock_item = ri_g;
        if (!m_active && !m_closing && rs_g && ($countones(ri_g) == 1))
            m_stock[idx_of(ri_g)] = SINIT;
`endif
        if (m_closing) begin
            e_rej = coin;
            m_credit = 0; m_closing = 0; m_active = 0;
        end else if (!m_active) begin
            if (coin && (c || s != 4'd0)) e_rej = 1;
            else if (coin) begin m_credit = cval; m_active = 1; m_idle = 0; end
        end else begin
            if (coin && (c || s != 4'd0)) e_rej = 1;
            if (c) refund_now();
            else if (sel_new) begin
                m_idle = 0;
                if ($countones(s) != 1) e_inv = 1;
                else begin
                    i = idx_of(s);
                    m_price = prices[i];
`ifdef VEND_STOCK_TRACK_EN
                    if (m_stock[i] == 0) e_so = s;
                    else
`endif
                    if (m_credit >= m_price) begin
                        e_vend = 1; e_sel = s; e_cv = 1; e_change = m_credit - m_price;
                        m_closing = 1; m_stock[i]--;
                    end else e_funds = 1;
                end
            end else if (coin) begin
                m_idle = 0;
                if (s != 4'd0 || m_credit + cval > 65535) e_rej = 1;
                else m_credit += cval;
            end else if (m_idle == TMO - 1) refund_now();
            else m_idle++;
        end
        m_sel_prev = (s != 4'd0);
        @(posedge clk); #1;
        check_all();
    endtask

    task automatic idle_step();
        step(0, 0, 4'd0, 0);
    endtask

    initial begin
        int first;
        logic [3:0] sel_tab [8] = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd3, 4'd5, 4'd12, 4'd15};
        int coin_tab [7] = '{0, 5, 10, 25, 50, 100, 65000};
        logic [3:0] s;
`ifdef VEND_STOCK_TRACK_EN
        rs_g = 0; ri_g = '0;
`endif
        do_reset();
        do_reset();

        // Exact change: four 25s then item 0 (price 100).
        repeat (4) step(1, 25, 4'd0, 0);
        check("exact_credit", 32'(credit), 32'd100);
        step(0, 0, 4'b0001, 0);
        check("exact_vend", 32'(vend), 32'd1);
        check("exact_change", 32'(change), 32'd0);
        check("exact_cv", 32'(change_valid), 32'd1);
        idle_step();
        check("exact_credit_clr", 32'(credit), 32'd0);

        // Overpay: 200 for item 1 (price 75).
        step(1, 100, 4'd0, 0); step(1, 100, 4'd0, 0);
        step(0, 0, 4'b0010, 0);
        check("overpay_change", 32'(change), 32'd125);
        idle_step();

        // Invalid selection, then item 2 (price 150).
        step(1, 100, 4'd0, 0); step(1, 100, 4'd0, 0);
        step(0, 0, 4'b0011, 0);
        check("invalid_err", 32'(err_invalid), 32'd1);
        check("invalid_credit", 32'(credit), 32'd200);
        idle_step();
        step(0, 0, 4'b0100, 0);
        check("invalid_then_change", 32'(change), 32'd50);
        idle_step();

        // Insufficient funds for item 3 (price 125), then overflow reject.
        step(1, 50, 4'd0, 0);
        step(0, 0, 4'b1000, 0);
        check("funds_err", 32'(err_funds), 32'd1);
        check("funds_price", 32'(price), 32'd125);
        check("funds_credit", 32'(credit), 32'd50);
        step(0, 0, 4'd0, 1); idle_step();
        step(1, 65500, 4'd0, 0);
        step(1, 100, 4'd0, 0);
        check("ovf_reject", 32'(coin_reject), 32'd1);
        check("ovf_credit", 32'(credit), 32'd65500);
        step(0, 0, 4'd0, 1); idle_step();

        // Timeout refund exactly TMO cycles after the coin.
        step(1, 100, 4'd0, 0);
        first = -1;
        for (int k = 1; k <= 2 * TMO; k++) begin
            idle_step();
            if (change_valid && first < 0) begin
                first = k;
                check("tmo_change", 32'(change), 32'd100);
            end
        end
        check("tmo_cycles", 32'(first), 32'(TMO));

        // Cancel with a coin in the same cycle.
        step(1, 50, 4'd0, 0);
        step(1, 25, 4'd0, 1);
        check("cancel_reject", 32'(coin_reject), 32'd1);
        check("cancel_change", 32'(change), 32'd50);
        idle_step();

`ifdef VEND_STOCK_TRACK_EN
        // Item 0 already sold its single unit.
        step(1, 100, 4'd0, 0);
        step(0, 0, 4'b0001, 0);
        check("soldout_bit", 32'(sold_out), 32'd1);
        check("soldout_credit", 32'(credit), 32'd100);
        check("soldout_novend", 32'(vend), 32'd0);
        step(0, 0, 4'd0, 1); idle_step();
`endif

        // Reset mid-transaction discards credit without a refund pulse.
        step(1, 50, 4'd0, 0); step(1, 25, 4'd0, 0);
        check("rst_credit_before", 32'(credit), 32'd75);
        do_reset();
        check("rst_no_refund", 32'(change_valid), 32'd0);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
`ifdef VEND_STOCK_TRACK_EN
            rs_g = ($urandom_range(0, 9) == 0);
            ri_g = 4'(1 << $urandom_range(0, 3));
`endif
            s = ($urandom_range(0, 9) < 2) ? sel_tab[$urandom_range(0, 7)] : 4'd0;
            if ($urandom_range(0, 249) == 0) do_reset();
            else step($urandom_range(0, 99) < 40, coin_tab[$urandom_range(0, 6)], s,
                      $urandom_range(0, 29) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
